// File: rtl/fm_tuner_config_seq.sv
// FM tuner configuration sequencer: power-up delay, init-table writes, then
// single host writes, each one a watchdog-guarded write-only I2C transaction.
module fm_tuner_config_seq #(
  parameter int unsigned N_REGS      = 8,
  parameter logic [6:0]  DEV_ADDR    = 7'h11,
  parameter int unsigned WAIT_CYCLES = 50000,
  parameter int unsigned TIMEOUT     = 4000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REGS-1:0][15:0] init_data,
  input  logic                    host_req,
  input  logic [15:0]             host_data,
  output logic                    host_ack,
  output logic                    busy,
  output logic                    init_done,
  output logic                    error,
  output logic [6:0]              i2c_addr,
  output logic [1:0][7:0]         i2c_wdata,
  output logic                    i2c_req,
  input  logic                    i2c_ack
);

  localparam int unsigned CNT_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(N_REGS) + 1;

  typedef enum logic [2:0] {
    S_WAIT,
    S_INIT_REQ,
    S_INIT_WAIT,
    S_IDLE,
    S_HOST_REQ,
    S_HOST_WAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_sel;
  logic [15:0]      r_wdata, w_wdata_nxt, w_init_word;
  logic             r_req, w_req_nxt;
  logic             r_host_ack, w_host_ack_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             r_error, w_error_nxt;
  logic             w_wait_done, w_tmo, w_last;

  assign w_wait_done = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_last      = (r_idx == IDX_W'(N_REGS - 1));

  // The word register is loaded on entry to INIT_REQ, so the table is read
  // one entry ahead of idx while an init word is outstanding.
  always_comb begin
    w_idx_sel   = (r_state == S_INIT_WAIT) ? r_idx + IDX_W'(1) : r_idx;
    w_init_word = '0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if (w_idx_sel == IDX_W'(k)) w_init_word = init_data[k];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_wdata_nxt     = r_wdata;
    w_host_ack_nxt  = 1'b0;
    w_init_done_nxt = r_init_done;
    w_error_nxt     = r_error;
    case (r_state)
      S_WAIT: begin
        if (w_wait_done) begin
          w_state_nxt = S_INIT_REQ;
          w_wdata_nxt = w_init_word;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_INIT_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        // A coincident ack beats expiry, leaving the error flag untouched.
        if (i2c_ack || w_tmo) begin
          if (!i2c_ack) w_error_nxt = 1'b1;
          if (w_last) begin
            w_state_nxt     = S_IDLE;
            w_init_done_nxt = 1'b1;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_wdata_nxt = w_init_word;
            w_state_nxt = S_INIT_REQ;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (host_req) begin
          w_wdata_nxt = host_data;
          w_state_nxt = S_HOST_REQ;
        end
      end
      S_HOST_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_HOST_WAIT;
      end
      S_HOST_WAIT: begin
        if (i2c_ack || w_tmo) begin
          if (!i2c_ack) w_error_nxt = 1'b1;
          w_host_ack_nxt = 1'b1;
          w_state_nxt    = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
    w_req_nxt  = (w_state_nxt == S_INIT_REQ) || (w_state_nxt == S_HOST_REQ);
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_req       <= 1'b0;
      r_host_ack  <= 1'b0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_wdata     <= w_wdata_nxt;
      r_req       <= w_req_nxt;
      r_host_ack  <= w_host_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_init_done <= w_init_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign i2c_addr  = DEV_ADDR;
  assign i2c_wdata = r_wdata;
  assign i2c_req   = r_req;
  assign host_ack  = r_host_ack;
  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign error     = r_error;

endmodule
